// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the sequential FP subtractor:
// field widths, output constants, FSM states and the final result packer.
package fp_pkg;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned FP_W    = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W   = MAN_W + 1;
  localparam int unsigned SUM_W   = SIG_W + 1;
  localparam int unsigned EXPR_W  = 10;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned CNT_MAX = SIG_W;
  localparam int unsigned EXP_MAX = 2 * BIAS + 1;

  localparam logic [FP_W-1:0] FP_INF_OUT = 32'h7FFF_FFFF;
  localparam logic [FP_W-1:0] FP_ZERO    = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } fp_state_e;

  // Saturates out-of-range exponents to the fixed overflow / zero encodings.
  function automatic logic [FP_W-1:0] fp_pack(input logic                     sign,
                                              input logic signed [EXPR_W-1:0] e,
                                              input logic [MAN_W-1:0]         man);
    if (e >= $signed(EXPR_W'(EXP_MAX)))  fp_pack = FP_INF_OUT;
    else if (e < $signed(EXPR_W'(1)))    fp_pack = FP_ZERO;
    else                                 fp_pack = {sign, e[EXP_W-1:0], man};
  endfunction
endpackage

// File: rtl/adder_subtractor.sv
// 25-bit significand adder/subtractor shared by the FP datapath.
module adder_subtractor
  import fp_pkg::*;
(
  input  logic [SUM_W-1:0] i_a,
  input  logic [SUM_W-1:0] i_b,
  input  logic             i_sub,
  output logic [SUM_W-1:0] o_sum_c
);
  assign o_sum_c = i_sub ? (i_a - i_b) : (i_a + i_b);
endmodule

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle single-precision subtractor (a - b), truncating, with
// one-bit-per-cycle alignment and normalisation shifters.
module fp_subtractor_seq
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [FP_W-1:0] out
);
  fp_state_e                r_state;
  logic [FP_W-1:0]          r_a;
  logic [FP_W-1:0]          r_b;
  logic [SIG_W-1:0]         r_m1;
  logic [SIG_W-1:0]         r_m2;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_sign;
  logic                     r_sub;
  logic signed [EXPR_W-1:0] r_exp;
  logic [SUM_W-1:0]         r_sum;
  logic                     r_busy;
  logic                     r_done;
  logic [FP_W-1:0]          r_out;

  logic [FP_W-1:0]          w_bf;
  logic                     w_any_inf;
  logic                     w_swap;
  logic [FP_W-1:0]          w_x1;
  logic [FP_W-1:0]          w_x2;
  logic [EXP_W-1:0]         w_ediff;
  logic [CNT_W-1:0]         w_cnt;
  logic [SUM_W-1:0]         w_sum;
  logic signed [EXPR_W-1:0] w_norm_exp;
  logic [MAN_W-1:0]         w_norm_man;

  // Subtraction becomes addition of b with its sign flipped.
  assign w_bf      = {~r_b[FP_W-1], r_b[FP_W-2:0]};
  assign w_any_inf = (r_a[FP_W-2:MAN_W] == '1) || (r_b[FP_W-2:MAN_W] == '1);

  // Exponent|mantissa compares as one unsigned magnitude; X1 is the larger.
  assign w_swap  = r_b[FP_W-2:0] > r_a[FP_W-2:0];
  assign w_x1    = w_swap ? w_bf : r_a;
  assign w_x2    = w_swap ? r_a  : w_bf;
  assign w_ediff = w_x1[FP_W-2:MAN_W] - w_x2[FP_W-2:MAN_W];
  assign w_cnt   = (w_ediff > EXP_W'(CNT_MAX)) ? CNT_W'(CNT_MAX) : CNT_W'(w_ediff);

  adder_subtractor u_addsub (
    .i_a     ({1'b0, r_m1}),
    .i_b     ({1'b0, r_m2}),
    .i_sub   (r_sub),
    .o_sum_c (w_sum)
  );

  // A carry out of the add is absorbed here in the same cycle it is seen.
  assign w_norm_exp = r_sum[SUM_W-1] ? (r_exp + $signed(EXPR_W'(1))) : r_exp;
  assign w_norm_man = r_sum[SUM_W-1] ? r_sum[SIG_W-1:1] : r_sum[MAN_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_m1    <= '0;
      r_m2    <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_sub   <= 1'b0;
      r_exp   <= '0;
      r_sum   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= FP_ZERO;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_busy  <= 1'b1;
            r_state <= ST_PREP;
          end
        end
        ST_PREP: begin
          if (w_any_inf) begin
            r_out   <= FP_INF_OUT;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_a[FP_W-2:0] == '0) begin
            r_out   <= w_bf;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_b[FP_W-2:0] == '0) begin
            r_out   <= r_a;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_m1    <= {1'b1, w_x1[MAN_W-1:0]};
            r_m2    <= {1'b1, w_x2[MAN_W-1:0]};
            r_sign  <= w_x1[FP_W-1];
            r_sub   <= w_x1[FP_W-1] ^ w_x2[FP_W-1];
            r_exp   <= $signed(EXPR_W'(w_x1[FP_W-2:MAN_W]));
            r_cnt   <= w_cnt;
            r_state <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (r_cnt != '0) begin
            r_m2  <= r_m2 >> 1;
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_sum   <= w_sum;
          r_state <= ST_NORM;
        end
        ST_NORM: begin
          if (r_sum == '0) begin
            r_out   <= FP_ZERO;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_sum[SUM_W-1] || r_sum[SUM_W-2]) begin
            r_out   <= fp_pack(r_sign, w_norm_exp, w_norm_man);
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - $signed(EXPR_W'(1));
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_out;
endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Scoreboard bench for fp_subtractor_seq: directed and random a-b vectors
// against an arithmetic reference model, with latency and reset checks.
module tb_fp_subtractor_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] out;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          st;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  fp_subtractor_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: value-level a-b with truncation, leading-one search for normalisation.
  function automatic void ref_sub(input logic [31:0] ra, input logic [31:0] rb,
                                  output logic [31:0] r, output int lat);
    logic [31:0] bf, x1, x2;
    longint      m1, m2, s;
    int          e1, e2, cnt, n, e, p;
    bf  = {~rb[31], rb[30:0]};
    lat = 1;
    if (ra[30:23] == 8'hFF || rb[30:23] == 8'hFF) r = 32'h7FFFFFFF;
    else if (ra[30:0] == 31'd0) r = bf;
    else if (rb[30:0] == 31'd0) r = ra;
    else begin
      if (bf[30:0] > ra[30:0]) begin x1 = bf; x2 = ra; end
      else begin x1 = ra; x2 = bf; end
      e1  = int'(x1[30:23]);
      e2  = int'(x2[30:23]);
      m1  = longint'({1'b1, x1[22:0]});
      m2  = longint'({1'b1, x2[22:0]});
      cnt = (e1 - e2 > 24) ? 24 : e1 - e2;
      m2  = m2 >> cnt;
      s   = (x1[31] == x2[31]) ? m1 + m2 : m1 - m2;
      n   = 0;
      if (s == 0) r = 32'h0;
      else begin
        p = 0;
        for (int i = 0; i < 25; i++) if (s[i]) p = i;
        if (p == 24) begin e = e1 + 1; s = s >> 1; end
        else begin n = 23 - p; e = e1 - n; s = s << n; end
        if (e >= 255)    r = 32'h7FFFFFFF;
        else if (e <= 0) r = 32'h0;
        else             r = {x1[31], 8'(e), s[22:0]};
      end
      lat = 4 + cnt + n;
    end
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] eo, input int el);
    exp_t e;
    wait_idle();
    e.res = eo;
    e.lat = el;
    e.st  = cyc + 1;
    sb.push_back(e);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_model(input logic [31:0] ta, input logic [31:0] tb_v);
    logic [31:0] r;
    int          l;
    ref_sub(ta, tb_v, r, l);
    issue(ta, tb_v, r, l);
  endtask

  // Monitor: pops one expectation per done pulse, then checks done/busy drop.
  initial begin
    exp_t e;
    bit   chk_after = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_after) begin
        chk_after = 1'b0;
        check("after_done_busy_done", {30'd0, busy, done}, 32'd0);
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual out=%h required no done pulse", out);
        end else begin
          e = sb.pop_front();
          check("result", out, e.res);
          check("latency", 32'(cyc - e.st), 32'(e.lat));
          chk_after = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    int          md, ea, eb, k;
    start = 1'b0;
    a     = '0;
    b     = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_out", out, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h40400000, 32'h3F800000, 32'h40000000, 5);
    issue(32'h3F800000, 32'hBF800000, 32'h40000000, 4);
    issue(32'h3F800000, 32'h3F800000, 32'h00000000, 4);
    issue(32'h7F800000, 32'h3F800000, 32'h7FFFFFFF, 1);
    issue(32'h00000000, 32'h40A00000, 32'hC0A00000, 1);
    issue(32'h40A00000, 32'h00000000, 32'h40A00000, 1);

    // 10 - 1 = 9 with a second start landing in ALIGN that must be ignored.
    issue(32'h41200000, 32'h3F800000, 32'h41100000, 7);
    @(negedge clk);
    start = 1'b1;
    a     = 32'h40000000;
    b     = 32'h40400000;
    @(negedge clk);
    start = 1'b0;

    // Reset while normalising a one-ulp difference (23 left shifts).
    wait_idle();
    start = 1'b1;
    a     = 32'h3F800001;
    b     = 32'h3F800000;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_reset_busy", {31'd0, busy}, 32'd0);
    check("midop_reset_done", {31'd0, done}, 32'd0);
    check("midop_reset_out", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue_model(32'h3F800001, 32'h3F800000);
    for (int t = 0; t < 400; t++) begin
      md = int'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      ea = int'($urandom_range(1, 254));
      case (md)
        1, 2: begin
          eb = ea + int'($urandom_range(0, 60)) - 30;
          if (eb < 0) eb = 0;
          if (eb > 254) eb = 254;
          ra[30:23] = 8'(ea);
          rb[30:23] = 8'(eb);
        end
        3: begin
          ra[30:23] = 8'(ea);
          rb = ra ^ 32'($urandom_range(0, 1023));
        end
        4: begin
          ra[30:23] = 8'd254;
          rb[30:23] = 8'($urandom_range(250, 254));
          rb[31]    = ~ra[31];
        end
        5: begin
          ra[30:23] = 8'($urandom_range(1, 3));
          rb = ra ^ 32'($urandom_range(1, 1 << 22));
        end
        6: begin
          if ($urandom_range(0, 1) == 1) ra[30:0] = '0;
          else rb[30:0] = '0;
        end
        7: begin
          if ($urandom_range(0, 1) == 1) ra[30:23] = 8'hFF;
          else rb[30:23] = 8'hFF;
        end
        default: ;
      endcase
      issue_model(ra, rb);
    end

    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
